shifter_ll_seq: RTL



---
 rtl/shifter_ll_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/shifter_ll_seq.sv
// Multi-cycle logical left shifter: resolves one shift-amount bit per clock
// (stage k shifts by 2^k), valid/ready handshakes on input and output.
module shifter_ll_seq #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y
);

  // Handshake rule (both sides): a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds its payload stable
  // while valid is high and ready is low.

  localparam int KW   = $clog2(SW) + 1;
  localparam int LOGN = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic [SW-1:0] sreg;
  logic [SW-1:0] sreg_next;
  logic [KW-1:0] k;
  logic [KW-1:0] k_next;

  logic          stage_bit;
  logic [N-1:0]  stage_val;

  // Stages whose distance 2^k reaches the width push every bit out.
  always_comb begin
    stage_bit = |(sreg & (SW'(1) << k));
    if (int'(k) >= LOGN) begin
      stage_val = '0;
    end else begin
      stage_val = acc << (32'd1 << k);
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign y         = acc;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    sreg_next  = sreg;
    k_next     = k;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          acc_next   = a;
          sreg_next  = s;
          k_next     = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (stage_bit) begin
          acc_next = stage_val;
        end
        k_next = k + KW'(1);
        if (k == KW'(SW - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // acc is kept so y holds its last value after the handshake.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sreg  <= '0;
      k     <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      sreg  <= sreg_next;
      k     <= k_next;
    end
  end

endmodule
